// File: rtl/down_count_monitor.sv
// rtl/down_count_monitor.sv - threshold alarm, wrap detector and arm-to-fire timer on a down count
// Samples the free-running count each edge; all outputs are registered one clock after the sampling edge.
module down_count_monitor #(
  parameter int N     = 10,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     count,
  input  logic             arm,
  input  logic [N-1:0]     thresh,
  input  logic             ack,
  input  logic             clr_wrap,
  output logic             alarm,
  output logic             alarm_pulse,
  output logic             wrap_pulse,
  output logic [EVT_W-1:0] wrap_cnt,
  output logic [N-1:0]     elapsed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     count_q;
  logic             sample_valid_q;
  logic [N-1:0]     thresh_q, thresh_d;
  logic [N-1:0]     cyc_q, cyc_d;
  logic             alarm_q, alarm_d;
  logic             alarm_pulse_q, alarm_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [EVT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [N-1:0]     elapsed_q, elapsed_d;

  logic [N-1:0]     cyc_inc;
  logic             match;

  // sample_valid_q keeps the reset value of count_q (0) from looking like the low side of a wrap
  assign wrap_pulse_d = sample_valid_q && (count_q == '0) && (count == '1);
  assign match        = (count == thresh_q);
  assign cyc_inc      = (cyc_q == '1) ? cyc_q : cyc_q + N'(1);

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr_wrap) begin
      wrap_cnt_d = '0;
    end else if (wrap_pulse_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + EVT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    thresh_d      = thresh_q;
    cyc_d         = cyc_q;
    alarm_d       = alarm_q;
    alarm_pulse_d = 1'b0;
    elapsed_d     = elapsed_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = ARMED;
          thresh_d = thresh;
          cyc_d    = '0;
        end
      end
      ARMED: begin
        // the fire edge itself counts as one edge spent armed
        if (match) begin
          state_d       = FIRED;
          alarm_d       = 1'b1;
          alarm_pulse_d = 1'b1;
          elapsed_d     = cyc_inc;
          cyc_d         = cyc_inc;
        end else if (arm) begin
          thresh_d = thresh;
          cyc_d    = '0;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      FIRED: begin
        if (ack) begin
          alarm_d = 1'b0;
          if (arm) begin
            state_d  = ARMED;
            thresh_d = thresh;
            cyc_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        alarm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      sample_valid_q <= 1'b0;
      thresh_q       <= '0;
      cyc_q          <= '0;
      alarm_q        <= 1'b0;
      alarm_pulse_q  <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      wrap_cnt_q     <= '0;
      elapsed_q      <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count;
      sample_valid_q <= 1'b1;
      thresh_q       <= thresh_d;
      cyc_q          <= cyc_d;
      alarm_q        <= alarm_d;
      alarm_pulse_q  <= alarm_pulse_d;
      wrap_pulse_q   <= wrap_pulse_d;
      wrap_cnt_q     <= wrap_cnt_d;
      elapsed_q      <= elapsed_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_pulse = alarm_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign elapsed     = elapsed_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// tb/tb_down_count_monitor.sv - scoreboard bench for down_count_monitor
// Expected outputs come from an edge-numbered reference model; a monitor pops one record per clock.
module tb_down_count_monitor;

  localparam int N     = 10;
  localparam int EVT_W = 2;
  localparam int MAXC  = (1 << N) - 1;
  localparam int MAXW  = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     count = '0;
  logic             arm = 1'b0;
  logic [N-1:0]     thresh = '0;
  logic             ack = 1'b0;
  logic             clr_wrap = 1'b0;
  logic             alarm;
  logic             alarm_pulse;
  logic             wrap_pulse;
  logic [EVT_W-1:0] wrap_cnt;
  logic [N-1:0]     elapsed;

  down_count_monitor #(.N(N), .EVT_W(EVT_W)) dut (
    .clk(clk), .reset(reset), .count(count), .arm(arm), .thresh(thresh),
    .ack(ack), .clr_wrap(clr_wrap), .alarm(alarm), .alarm_pulse(alarm_pulse),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             alarm;
    logic             apulse;
    logic             wpulse;
    logic [EVT_W-1:0] wcnt;
    logic [N-1:0]     el;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: mode 0 idle, 1 armed, 2 fired; timing by absolute edge number
  int   m_mode, m_th, m_edge, m_arm_edge, m_prev, m_wcnt, m_el;
  bit   m_valid, m_alarm;
  logic [N-1:0] cnt_r;

  function automatic void model_reset();
    m_mode = 0; m_th = 0; m_edge = 0; m_arm_edge = 0; m_prev = 0;
    m_wcnt = 0; m_el = 0; m_valid = 0; m_alarm = 0;
  endfunction

  function automatic exp_t model_step(int c, bit a, int th, bit k, bit clr);
    exp_t r;
    bit   wrap, pulse;
    m_edge++;
    wrap  = m_valid && (m_prev == 0) && (c == MAXC);
    pulse = 0;
    if (m_mode == 0) begin
      if (a) begin m_mode = 1; m_th = th; m_arm_edge = m_edge; end
    end else if (m_mode == 1) begin
      if (c == m_th) begin
        m_mode = 2; m_alarm = 1; pulse = 1;
        m_el = (m_edge - m_arm_edge > MAXC) ? MAXC : m_edge - m_arm_edge;
      end else if (a) begin
        m_th = th; m_arm_edge = m_edge;
      end
    end else if (k) begin
      m_alarm = 0;
      if (a) begin m_mode = 1; m_th = th; m_arm_edge = m_edge; end
      else m_mode = 0;
    end
    if (clr) m_wcnt = 0;
    else if (wrap && m_wcnt < MAXW) m_wcnt++;
    m_prev = c; m_valid = 1;
    r.alarm = m_alarm; r.apulse = pulse; r.wpulse = wrap;
    r.wcnt = EVT_W'(m_wcnt); r.el = N'(m_el);
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if ({alarm, alarm_pulse, wrap_pulse, wrap_cnt, elapsed} != mon_e) begin
          n_bad++;
          $display("FAIL outputs: got alarm=%0b pulse=%0b wrap=%0b wcnt=%0d el=%0d expected alarm=%0b pulse=%0b wrap=%0b wcnt=%0d el=%0d at %0t",
                   alarm, alarm_pulse, wrap_pulse, wrap_cnt, elapsed,
                   mon_e.alarm, mon_e.apulse, mon_e.wpulse, mon_e.wcnt, mon_e.el, $time);
        end
      end
    end
  end

  task automatic step(bit a, logic [N-1:0] th, bit k, bit c);
    arm = a; thresh = th; ack = k; clr_wrap = c; count = cnt_r;
    sb.push_back(model_step(int'(cnt_r), a, int'(th), k, c));
    @(posedge clk);
    #2;
    cnt_r = cnt_r - N'(1);
    arm = 0; ack = 0; clr_wrap = 0;
  endtask

  task automatic run(int n);
    repeat (n) step(0, '0, 0, 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_alarm"}, int'(alarm), 0);
    check({tag, "_alarm_pulse"}, int'(alarm_pulse), 0);
    check({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
    check({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
    check({tag, "_elapsed"}, int'(elapsed), 0);
  endtask

  task automatic mid_reset();
    #3;
    reset = 0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1;
  endtask

  initial begin
    logic [N-1:0] off;
    bit a, k, c;
    model_reset();
    #1;
    check_zero("power_on_reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1;

    // first sample after reset is all-ones: must not look like a wrap
    cnt_r = N'(MAXC);
    run(3);

    cnt_r = N'(100);
    step(1, N'(40), 0, 0);
    run(65);
    check("alarm_after_fire", int'(alarm), 1);
    check("elapsed_60", int'(elapsed), 60);
    step(0, '0, 1, 0);
    check("alarm_after_ack", int'(alarm), 0);

    cnt_r = N'(2);
    run(5);
    check("wrap_cnt_first", int'(wrap_cnt), 1);

    repeat (5) begin
      cnt_r = N'(1);
      run(3);
    end
    check("wrap_cnt_saturated", int'(wrap_cnt), MAXW);
    cnt_r = '0;
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    check("clr_vs_wrap_pulse", int'(wrap_pulse), 1);
    check("clr_vs_wrap_cnt", int'(wrap_cnt), 0);

    cnt_r = N'(50);
    step(1, N'(30), 0, 0);
    run(25);
    step(1, N'(7), 0, 0);
    run(2);
    check("arm_without_ack_ignored", int'(alarm), 1);
    cnt_r = N'(10);
    step(1, N'(5), 1, 0);
    check("ack_arm_clears_alarm", int'(alarm), 0);
    run(8);
    check("rearmed_fire", int'(alarm), 1);

    step(1, cnt_r, 1, 0);
    run(1030);
    check("late_fire_alarm", int'(alarm), 1);
    check("elapsed_saturated", int'(elapsed), MAXC);

    mid_reset();
    cnt_r = N'(MAXC);
    run(4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cnt_r = N'($urandom);
      off = N'($urandom_range(0, 40));
      a = ($urandom_range(0, 15) == 0);
      k = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 63) == 0);
      step(a, cnt_r - off, k, c);
      if (i == 1500) begin
        mid_reset();
        cnt_r = N'(MAXC);
      end
    end

    run(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
